// File: rtl/pixel_writer_pkg.sv
// Shared types and helpers for the pixel writer: bus beat layout, FSM states,
// and the pixels-per-word calculation used to size the packer.
package pixel_writer_pkg;

    localparam int WORD_BYTES = 4;

    function automatic int ppw(input int pixel_bits);
        return 32 / pixel_bits;
    endfunction

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        write;
    } avalon_wr_t;

    typedef enum logic [1:0] {
        PW_IDLE,
        PW_RUN,
        PW_DONE
    } pw_state_t;

endpackage

// File: rtl/pixel_writer_sync_fifo.sv
// Show-ahead synchronous FIFO: dout always presents the oldest entry while
// non-empty. Synchronous reset empties it; storage is not cleared.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/pixel_writer.sv
// Packs a raster-order pixel stream into 32-bit words and writes one frame to
// a linear framebuffer over an Avalon-MM write master, then pulses frame_done.
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int H_RESOLUTION = 256,
    parameter int V_RESOLUTION = 192,
    parameter int PIXEL_BITS   = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           pixel_buffer,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [PIXEL_BITS-1:0] pix_color,
    output logic [31:0]           m1_address,
    output logic [31:0]           m1_writedata,
    output logic                  m1_write,
    input  logic                  m1_waitrequest,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int PPW          = ppw(PIXEL_BITS);
    localparam int TOTAL_PIXELS = H_RESOLUTION * V_RESOLUTION;
    localparam int TOTAL_WORDS  = TOTAL_PIXELS / PPW;
    localparam int LW           = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int WW           = $clog2(TOTAL_WORDS + 1);
    localparam int CW           = $clog2(TOTAL_PIXELS + 1);

    if (PIXEL_BITS != 8 && PIXEL_BITS != 16 && PIXEL_BITS != 32) begin : g_bad_pixel_bits
        $error("pixel_writer: PIXEL_BITS must be 8, 16 or 32");
    end
    if (TOTAL_PIXELS % PPW != 0) begin : g_bad_frame_size
        $error("pixel_writer: frame size is not a whole number of words");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("pixel_writer: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    pw_state_t      state_q, state_d;
    logic [31:0]    base_q, base_d;
    logic [WW-1:0]  word_idx_q, word_idx_d;
    logic [CW-1:0]  pix_cnt_q, pix_cnt_d;
    logic [LW-1:0]  lane_q, lane_d;
    logic [31:0]    pack_q, pack_d;

    logic           xfer, push, pop, fifo_full, fifo_empty;
    logic [31:0]    packed_word, fifo_dout;
    avalon_wr_t     m1;

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (packed_word),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Bus fields are gated to 0 when idle so every output reads 0 out of reset.
    always_comb begin
        m1       = '0;
        m1.write = !fifo_empty;
        if (!fifo_empty) begin
            m1.data = fifo_dout;
            m1.addr = base_q + 32'(word_idx_q) * 32'(WORD_BYTES);
        end
    end

    assign m1_address   = m1.addr;
    assign m1_writedata = m1.data;
    assign m1_write     = m1.write;

    assign pix_ready = (state_q == PW_RUN) && !fifo_full && (pix_cnt_q < CW'(TOTAL_PIXELS));
    assign xfer      = pix_valid && pix_ready;
    assign push      = xfer && (lane_q == LW'(PPW - 1));
    assign pop       = m1.write && !m1_waitrequest;

    always_comb begin
        packed_word = pack_q;
        packed_word[lane_q*PIXEL_BITS +: PIXEL_BITS] = pix_color;
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        word_idx_d = word_idx_q;
        pix_cnt_d  = pix_cnt_q;
        lane_d     = lane_q;
        pack_d     = pack_q;
        case (state_q)
            PW_IDLE: begin
                if (start) begin
                    state_d    = PW_RUN;
                    base_d     = {pixel_buffer[31:2], 2'b00};
                    word_idx_d = '0;
                    pix_cnt_d  = '0;
                    lane_d     = '0;
                    pack_d     = '0;
                end
            end
            PW_RUN: begin
                if (xfer) begin
                    pix_cnt_d = pix_cnt_q + CW'(1);
                    pack_d    = packed_word;
                    lane_d    = push ? '0 : lane_q + LW'(1);
                end
                if (pop) begin
                    word_idx_d = word_idx_q + WW'(1);
                    if (word_idx_q == WW'(TOTAL_WORDS - 1)) state_d = PW_DONE;
                end
            end
            PW_DONE: state_d = PW_IDLE;
            default: state_d = PW_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= PW_IDLE;
            base_q     <= '0;
            word_idx_q <= '0;
            pix_cnt_q  <= '0;
            lane_q     <= '0;
            pack_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            word_idx_q <= word_idx_d;
            pix_cnt_q  <= pix_cnt_d;
            lane_q     <= lane_d;
            pack_q     <= pack_d;
        end
    end

    assign busy       = (state_q != PW_IDLE);
    assign frame_done = (state_q == PW_DONE);

endmodule

// File: tb/tb_pixel_writer.sv
// Bench for pixel_writer: directed frames plus randomized frames checked
// against a word-level packing/address model and an expected-write queue.
module tb_pixel_writer;

    localparam int H = 4, V = 2, PB = 16, FD = 2;
    localparam int PPW = 32 / PB, NPIX = H * V, NWORDS = NPIX / PPW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1, start = 1'b0, pix_valid = 1'b0, m1_waitrequest = 1'b0;
    logic [31:0]   pixel_buffer = '0;
    logic [PB-1:0] pix_color = '0;
    logic          pix_ready, m1_write, busy, frame_done;
    logic [31:0]   m1_address, m1_writedata;

    logic          start_b = 1'b0, pix_valid_b = 1'b0, m1_waitrequest_b = 1'b0;
    logic [31:0]   pixel_buffer_b = '0;
    logic [7:0]    pix_color_b = '0;
    logic          pix_ready_b, m1_write_b, busy_b, frame_done_b;
    logic [31:0]   m1_address_b, m1_writedata_b;

    pixel_writer #(.H_RESOLUTION(H), .V_RESOLUTION(V), .PIXEL_BITS(PB), .FIFO_DEPTH(FD)) dut (
        .clock(clk), .reset(reset), .start(start), .pixel_buffer(pixel_buffer),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_color(pix_color),
        .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_write(m1_write),
        .m1_waitrequest(m1_waitrequest), .busy(busy), .frame_done(frame_done)
    );

    pixel_writer #(.H_RESOLUTION(8), .V_RESOLUTION(1), .PIXEL_BITS(8), .FIFO_DEPTH(FD)) dut_b (
        .clock(clk), .reset(reset), .start(start_b), .pixel_buffer(pixel_buffer_b),
        .pix_valid(pix_valid_b), .pix_ready(pix_ready_b), .pix_color(pix_color_b),
        .m1_address(m1_address_b), .m1_writedata(m1_writedata_b), .m1_write(m1_write_b),
        .m1_waitrequest(m1_waitrequest_b), .busy(busy_b), .frame_done(frame_done_b)
    );

    int checks = 0, failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard state: expected {address, data} per bus write, in order.
    logic [63:0]   exp_q[$];
    logic [63:0]   mon_e;
    logic [PB-1:0] pix_arr [NPIX];
    int cyc = 0, acc_cnt = 0, done_cnt = 0, start_cnt = 0, last_acc_cyc = -10;
    bit mon_en = 1'b0, prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_data;

    logic [63:0] b_q[$];
    int b_pix = 0, b_done = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (mon_en && prev_stall) begin
                check_eq("hold_write", 64'(m1_write), 64'(1));
                check_eq("hold_addr", 64'(m1_address), 64'(prev_addr));
                check_eq("hold_data", 64'(m1_writedata), 64'(prev_data));
            end
            if (mon_en && m1_write && !m1_waitrequest) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_write", 64'(1), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("write_addr", 64'(m1_address), 64'(mon_e[63:32]));
                    check_eq("write_data", 64'(m1_writedata), 64'(mon_e[31:0]));
                    if (exp_q.size() == 0) last_acc_cyc = cyc;
                end
            end
            if (frame_done) begin
                done_cnt++;
                if (mon_en) check_eq("done_latency", 64'(cyc - last_acc_cyc), 64'(1));
            end
            prev_stall = m1_write && m1_waitrequest;
            prev_addr  = m1_address;
            prev_data  = m1_writedata;
            if (m1_write_b && !m1_waitrequest_b) b_q.push_back({m1_address_b, m1_writedata_b});
            if (pix_valid_b && pix_ready_b) b_pix++;
            if (frame_done_b) b_done++;
        end
    end

    // Reference model: word j holds pixels j*PPW.., lowest column in the low bits.
    task automatic push_expected(input logic [31:0] base);
        logic [31:0] data, addr;
        for (int j = 0; j < NWORDS; j++) begin
            data = '0;
            for (int k = 0; k < PPW; k++) data = data | (32'(pix_arr[j*PPW+k]) << (k*PB));
            addr = (base & 32'hFFFF_FFFC) + 32'(j * 4);
            exp_q.push_back({addr, data});
        end
    endtask

    task automatic drive_frame(input logic [31:0] base, input int valid_pct, input int wait_pct,
                               input int stall_word, input int spurious_at);
        int idx = 0, n = 0, stall_left = 5, d0, a0;
        bit chk_full;
        push_expected(base);
        d0 = done_cnt;
        a0 = acc_cnt;
        @(posedge clk); #1;
        start = 1'b1; pixel_buffer = base; pix_valid = 1'b0; m1_waitrequest = 1'b0;
        start_cnt++;
        while (done_cnt == d0 && n < 400) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            pixel_buffer = $urandom();
            if (spurious_at >= 0 && idx == spurious_at) begin
                start = 1'b1;
                pixel_buffer = 32'hDEAD_0000;
            end
            if (idx < NPIX) begin
                pix_valid = ($urandom_range(0, 99) < valid_pct);
                pix_color = pix_arr[idx];
            end else begin
                pix_valid = 1'($urandom_range(0, 1));
                pix_color = PB'($urandom());
            end
            chk_full = 1'b0;
            if (stall_word > 0 && (acc_cnt - a0) == stall_word - 1 && m1_write && stall_left > 0) begin
                m1_waitrequest = 1'b1;
                stall_left--;
                chk_full = (stall_left == 0);
            end else begin
                m1_waitrequest = ($urandom_range(0, 99) < wait_pct);
            end
            @(negedge clk);
            if (n == 1) check_eq("busy_in_run", 64'(busy), 64'(1));
            if (chk_full) check_eq("ready_when_full", 64'(pix_ready), 64'(0));
            if (idx >= NPIX && pix_valid) check_eq("extra_pixel_ready", 64'(pix_ready), 64'(0));
            if (pix_valid && pix_ready && idx < NPIX) idx++;
        end
        if (done_cnt == d0) check_eq("frame_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        start = 1'b0; pix_valid = 1'b0; m1_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("done_once", 64'(done_cnt - d0), 64'(1));
        check_eq("words_left", 64'(exp_q.size()), 64'(0));
        check_eq("idle_after_frame", 64'(busy), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, 64'(pix_ready), 64'(0));
        check_eq({tag, "_addr"}, 64'(m1_address), 64'(0));
        check_eq({tag, "_data"}, 64'(m1_writedata), 64'(0));
        check_eq({tag, "_write"}, 64'(m1_write), 64'(0));
        check_eq({tag, "_busy"}, 64'(busy), 64'(0));
        check_eq({tag, "_done"}, 64'(frame_done), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int xf, a0, bidx;
        logic [31:0] exp_w;
        // Reset state of both instances.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        check_eq("reset_b_write", 64'(m1_write_b), 64'(0));
        check_eq("reset_b_busy", 64'(busy_b), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // Basic frame with fixed colours and a misaligned base.
        for (int i = 0; i < NPIX; i++) pix_arr[i] = PB'(16'h1111 * (i + 1));
        drive_frame(32'h0800_0002, 100, 0, 0, -1);

        // Long stall on the second write.
        for (int i = 0; i < NPIX; i++) pix_arr[i] = PB'($urandom());
        drive_frame(32'h0000_4000, 100, 0, 2, -1);

        // Reset in the middle of a frame after three pixels.
        mon_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; pixel_buffer = 32'h0000_1000;
        @(posedge clk); #1;
        start = 1'b0; pix_valid = 1'b1; pix_color = PB'($urandom());
        xf = 0;
        for (int c = 0; c < 50 && xf < 3; c++) begin
            @(negedge clk);
            if (pix_valid && pix_ready) xf++;
            if (xf < 3) begin
                @(posedge clk); #1;
                pix_color = PB'($urandom());
            end
        end
        check_eq("abort_pixels", 64'(xf), 64'(3));
        @(posedge clk); #1;
        pix_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        exp_q.delete();
        mon_en = 1'b1;
        a0 = acc_cnt;
        for (int i = 0; i < NPIX; i++) pix_arr[i] = PB'($urandom());
        drive_frame(32'h0003_0000, 100, 0, 0, -1);
        check_eq("writes_after_reset", 64'(acc_cnt - a0), 64'(NWORDS));

        // A start during RUN must not move the base.
        for (int i = 0; i < NPIX; i++) pix_arr[i] = PB'($urandom());
        drive_frame(32'h0000_8000, 100, 0, 0, 3);

        // 8-bit pixel instance: 8x1 frame, valid held high past the last pixel.
        @(posedge clk); #1;
        start_b = 1'b1; pixel_buffer_b = 32'h0000_2000;
        @(posedge clk); #1;
        start_b = 1'b0;
        bidx = 0;
        for (int c = 0; c < 30; c++) begin
            pix_valid_b = 1'b1;
            pix_color_b = (bidx < 8) ? 8'(bidx + 1) : 8'hFF;
            @(negedge clk);
            if (pix_valid_b && pix_ready_b) bidx++;
            @(posedge clk); #1;
        end
        pix_valid_b = 1'b0;
        check_eq("b_pixels", 64'(b_pix), 64'(8));
        check_eq("b_writes", 64'(b_q.size()), 64'(2));
        check_eq("b_done", 64'(b_done), 64'(1));
        for (int j = 0; j < 2; j++) begin
            exp_w = '0;
            for (int k = 0; k < 4; k++) exp_w = exp_w | (32'(j * 4 + k + 1) << (k * 8));
            if (b_q.size() > 0) begin
                mon_e = b_q.pop_front();
                check_eq("b_addr", 64'(mon_e[63:32]), 64'(32'h0000_2000 + 32'(j * 4)));
                check_eq("b_data", 64'(mon_e[31:0]), 64'(exp_w));
            end
        end

        // Randomized frames: random colours, bases, valid gaps and stalls.
        for (int f = 0; f < 1000; f++) begin
            for (int i = 0; i < NPIX; i++) pix_arr[i] = PB'($urandom());
            drive_frame($urandom(), 70, 30, 0, -1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        check_eq("done_vs_start", 64'(done_cnt), 64'(start_cnt));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
